// File: rtl/mgmt_sram_pkg.sv
// Shared constants and FSM state type for the management-core SRAM controller.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package mgmt_sram_pkg;

  // Geometry of the 512x32 single-port macro wrapper.
  localparam int SRAM_ADDR_WIDTH = 9;
  localparam int SRAM_NUM_WMASKS = 4;
  localparam int SRAM_DATA_WIDTH = 32;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    ACK    = 2'd3
  } state_t;

endpackage

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave mapping a word-aligned address window onto SRAM port 0.
// Latency: write ack 2 cycles after the hit, read ack (with data) 3 cycles after.
// Backpressure: the bus waits for wb_ack_o; one access in flight, next hit taken the cycle after ack.
module wb_sram_ctrl
  import mgmt_sram_pkg::*;
#(
  parameter int          ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int          DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int          NUM_WMASKS = SRAM_NUM_WMASKS,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  core_clk,
  input  logic                  core_rstn,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [NUM_WMASKS-1:0] wb_sel_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  state_t                state_q, state_d;
  logic                  ack_d;
  logic [DATA_WIDTH-1:0] dat_d;
  logic                  csb_d;
  logic                  web_d;
  logic [NUM_WMASKS-1:0] wmask_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] din_d;

  logic                  hit;
  logic [ADDR_WIDTH-1:0] word_addr;

  // The byte offset within a word plays no part in a word access.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^wb_adr_i[1:0];

  // Window decode: upper address bits must match the aligned base.
  assign hit       = wb_cyc_i && wb_stb_i &&
                     (wb_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign word_addr = wb_adr_i[ADDR_WIDTH+1:2];

  // State and every output are registered here; reset parks the macro deselected at once.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state_q     <= IDLE;
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= '0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
    end else begin
      state_q     <= state_d;
      wb_ack_o    <= ack_d;
      wb_dat_o    <= dat_d;
      sram_csb0   <= csb_d;
      sram_web0   <= web_d;
      sram_wmask0 <= wmask_d;
      sram_addr0  <= addr_d;
      sram_din0   <= din_d;
    end
  end

  // Next state and next register values; everything holds unless the state says otherwise.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dat_d   = wb_dat_o;
    csb_d   = sram_csb0;
    web_d   = sram_web0;
    wmask_d = sram_wmask0;
    addr_d  = sram_addr0;
    din_d   = sram_din0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          addr_d  = word_addr;
          din_d   = wb_dat_i;
          web_d   = ~wb_we_i;
          wmask_d = wb_we_i ? wb_sel_i : '0;
          // A write with no byte lanes is acked but never selects the macro.
          csb_d   = wb_we_i && (wb_sel_i == '0);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // The macro samples at the end of this cycle; deselect for the next one.
        csb_d   = 1'b1;
        web_d   = 1'b1;
        wmask_d = '0;
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (!sram_web0) begin
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else begin
          dat_d   = sram_dout0;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        // Ack is visible this cycle; the bus is not re-sampled until back in IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Self-checking bench for wb_sram_ctrl with a behavioural SRAM and a reference memory model.
// Latency: measured per transaction in clock cycles from the hit cycle to the ack cycle.
// Backpressure: the bench holds each request until ack or a 10-cycle bound.
module tb_wb_sram_ctrl;

  localparam int          AW   = 9;
  localparam int          NW   = 1 << AW;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        core_clk = 1'b0;
  logic        core_rstn = 1'b0;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = 4'h0;
  logic [31:0] wb_adr_i = 32'h0, wb_dat_i = 32'h0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;

  int total = 0;
  int bad   = 0;

  always #5 core_clk = ~core_clk;

  wb_sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_WMASKS(4), .BASE_ADDR(BASE)) dut (
    .core_clk(core_clk), .core_rstn(core_rstn),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  // Behavioural SRAM macro: synchronous read, byte-masked write.
  logic [31:0] mem [NW];
  always @(posedge core_clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  // Reference memory: what the window should contain after each spec-level transaction.
  logic [31:0] ref_mem [NW];

  function automatic void model_apply(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                                      input logic [31:0] dat, output int lat, output logic [31:0] rexp,
                                      output logic touches);
    int  w;
    bit  is_hit;
    is_hit  = (adr >> (AW + 2)) == (BASE >> (AW + 2));
    w       = int'((adr >> 2) % NW);
    rexp    = ref_mem[w];
    touches = is_hit && !(we && sel == 4'h0);
    if (!is_hit) begin
      lat = -1;
    end else if (we) begin
      lat = 2;
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[w][8*b +: 8] = dat[8*b +: 8];
    end else begin
      lat = 3;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One bus transaction: hit presented in cycle 0, ack looked for in cycles 1..10.
  task automatic txn(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                     output int lat, output logic [31:0] rd, output logic saw_csb,
                     output logic c1_csb, output logic c1_web, output logic [3:0] c1_mask,
                     output logic [8:0] c1_addr);
    @(negedge core_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
    lat = -1; rd = 32'h0; saw_csb = 1'b0;
    c1_csb = 1'b1; c1_web = 1'b1; c1_mask = 4'h0; c1_addr = 9'h0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge core_clk);
      if (c == 1) begin
        c1_csb = sram_csb0; c1_web = sram_web0; c1_mask = sram_wmask0; c1_addr = sram_addr0;
        wb_dat_i = ~dat;     // later changes to the request must be ignored
        wb_sel_i = ~sel;
      end
      if (!sram_csb0) saw_csb = 1'b1;
      if (wb_ack_o) begin
        lat = c;
        rd  = wb_dat_o;
        break;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          exp_lat;
    logic        chk_dat;
    logic [31:0] exp_dat;
    logic [8:0]  exp_addr;
    logic [3:0]  exp_mask;
    logic        exp_csb_seen;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, mlat, acks, csbs;
    logic [31:0] rd, rexp;
    logic        saw, c1_csb, c1_web, touch;
    logic [3:0]  c1_mask;
    logic [8:0]  c1_addr;
    int          words [16];

    vt[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 2,  1'b0, 32'h0,         9'd4,   4'hF, 1'b1};
    vt[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         3,  1'b1, 32'hDEAD_BEEF, 9'd4,   4'h0, 1'b1};
    vt[2]  = '{1'b1, 32'h0000_001C, 4'hF, 32'h1122_3344, 2,  1'b0, 32'h0,         9'd7,   4'hF, 1'b1};
    vt[3]  = '{1'b1, 32'h0000_001C, 4'h5, 32'hAABB_CCDD, 2,  1'b0, 32'h0,         9'd7,   4'h5, 1'b1};
    vt[4]  = '{1'b0, 32'h0000_001E, 4'h0, 32'h0,         3,  1'b1, 32'h11BB_33DD, 9'd7,   4'h0, 1'b1};
    vt[5]  = '{1'b1, 32'h0000_07FC, 4'hF, 32'hCAFE_F00D, 2,  1'b0, 32'h0,         9'd511, 4'hF, 1'b1};
    vt[6]  = '{1'b0, 32'h0000_07FC, 4'hF, 32'h0,         3,  1'b1, 32'hCAFE_F00D, 9'd511, 4'h0, 1'b1};
    vt[7]  = '{1'b1, 32'h0000_0800, 4'hF, 32'h5555_5555, -1, 1'b0, 32'h0,         9'd0,   4'h0, 1'b0};
    vt[8]  = '{1'b0, 32'hFFFF_F7FC, 4'hF, 32'h0,         -1, 1'b0, 32'h0,         9'd0,   4'h0, 1'b0};
    vt[9]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h1234_5678, 2,  1'b0, 32'h0,         9'd8,   4'hF, 1'b1};
    vt[10] = '{1'b1, 32'h0000_0020, 4'h0, 32'hFFFF_FFFF, 2,  1'b0, 32'h0,         9'd8,   4'h0, 1'b0};
    vt[11] = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         3,  1'b1, 32'h1234_5678, 9'd8,   4'h0, 1'b1};

    // Reset values while reset is held.
    #12;
    check("rst ack",   32'(wb_ack_o),    32'h0);
    check("rst dat",   wb_dat_o,         32'h0);
    check("rst csb",   32'(sram_csb0),   32'h1);
    check("rst web",   32'(sram_web0),   32'h1);
    check("rst wmask", 32'(sram_wmask0), 32'h0);
    check("rst addr",  32'(sram_addr0),  32'h0);
    check("rst din",   sram_din0,        32'h0);
    @(negedge core_clk);
    core_rstn = 1'b1;

    // Directed table.
    for (int i = 0; i < NV; i++) begin
      txn(vt[i].we, vt[i].adr, vt[i].sel, vt[i].dat, lat, rd, saw, c1_csb, c1_web, c1_mask, c1_addr);
      model_apply(vt[i].we, vt[i].adr, vt[i].sel, vt[i].dat, mlat, rexp, touch);
      check($sformatf("v%0d lat", i),      32'(lat), 32'(vt[i].exp_lat));
      check($sformatf("v%0d csb_seen", i), 32'(saw), 32'(vt[i].exp_csb_seen));
      if (vt[i].exp_lat >= 0) begin
        check($sformatf("v%0d c1_csb", i),  32'(c1_csb),  32'(!vt[i].exp_csb_seen));
        check($sformatf("v%0d c1_web", i),  32'(c1_web),  32'(!vt[i].we));
        check($sformatf("v%0d c1_mask", i), 32'(c1_mask), 32'(vt[i].exp_mask));
        check($sformatf("v%0d c1_addr", i), 32'(c1_addr), 32'(vt[i].exp_addr));
      end
      if (vt[i].chk_dat) check($sformatf("v%0d rdata", i), rd, vt[i].exp_dat);
    end

    // Abort a read in RDWAIT: no ack, read data register untouched.
    @(negedge core_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0000_001C; wb_sel_i = 4'hF;
    acks = 0;
    @(negedge core_clk);
    if (wb_ack_o) acks++;
    @(negedge core_clk);
    if (wb_ack_o) acks++;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (6) begin
      @(negedge core_clk);
      if (wb_ack_o) acks++;
    end
    check("abort acks",     32'(acks), 32'h0);
    check("abort dat hold", wb_dat_o,  32'h1234_5678);
    txn(1'b0, 32'h0000_001C, 4'hF, 32'h0, lat, rd, saw, c1_csb, c1_web, c1_mask, c1_addr);
    check("post-abort lat",   32'(lat), 32'd3);
    check("post-abort rdata", rd,       32'h11BB_33DD);

    // Reset asserted while the read is in ACCESS.
    @(negedge core_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0000_0010; wb_sel_i = 4'hF;
    @(negedge core_clk);
    check("pre-reset csb", 32'(sram_csb0), 32'h0);
    #2 core_rstn = 1'b0;
    #1;
    check("midrst csb",   32'(sram_csb0),   32'h1);
    check("midrst ack",   32'(wb_ack_o),    32'h0);
    check("midrst dat",   wb_dat_o,         32'h0);
    check("midrst wmask", 32'(sram_wmask0), 32'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge core_clk);
    @(negedge core_clk);
    core_rstn = 1'b1;
    txn(1'b1, 32'h0000_0024, 4'hF, 32'hA5A5_5A5A, lat, rd, saw, c1_csb, c1_web, c1_mask, c1_addr);
    model_apply(1'b1, 32'h0000_0024, 4'hF, 32'hA5A5_5A5A, mlat, rexp, touch);
    check("post-rst wr lat", 32'(lat), 32'd2);
    txn(1'b0, 32'h0000_0024, 4'hF, 32'h0, lat, rd, saw, c1_csb, c1_web, c1_mask, c1_addr);
    check("post-rst rd lat",   32'(lat), 32'd3);
    check("post-rst rd rdata", rd,       32'hA5A5_5A5A);

    // Strobe held through the ack cycle must not start a second access.
    @(negedge core_clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h0000_0028;
    wb_sel_i = 4'hF; wb_dat_i = 32'h0BAD_F00D;
    model_apply(1'b1, 32'h0000_0028, 4'hF, 32'h0BAD_F00D, mlat, rexp, touch);
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge core_clk);
      if (wb_ack_o) begin
        lat = c;
        break;
      end
    end
    check("held lat", 32'(lat), 32'd2);
    @(negedge core_clk);
    check("held ack pulse", 32'(wb_ack_o), 32'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    acks = 0; csbs = 0;
    repeat (6) begin
      @(negedge core_clk);
      if (wb_ack_o) acks++;
      if (!sram_csb0) csbs++;
    end
    check("held no retrigger ack", 32'(acks), 32'h0);
    check("held no retrigger csb", 32'(csbs), 32'h0);

    // Randomised traffic over a small word set at both ends of the window.
    for (int k = 0; k < 16; k++) words[k] = (k < 8) ? k : (NW - 16 + k);
    for (int k = 0; k < 16; k++) begin
      logic [31:0] a, d;
      a = BASE + 32'(words[k] * 4);
      d = $urandom;
      model_apply(1'b1, a, 4'hF, d, mlat, rexp, touch);
      txn(1'b1, a, 4'hF, d, lat, rd, saw, c1_csb, c1_web, c1_mask, c1_addr);
      check($sformatf("fill%0d lat", k), 32'(lat), 32'(mlat));
    end
    for (int n = 0; n < 200; n++) begin
      logic        we;
      logic [3:0]  sel;
      logic [31:0] a, d;
      we  = 1'($urandom_range(0, 1));
      sel = 4'($urandom_range(0, 15));
      d   = $urandom;
      if ($urandom_range(0, 7) == 0)
        a = (32'($urandom_range(1, (1 << 21) - 1)) << 11) | ($urandom & 32'h7FF);
      else
        a = BASE + 32'(words[$urandom_range(0, 15)] * 4) + 32'($urandom_range(0, 3));
      model_apply(we, a, sel, d, mlat, rexp, touch);
      txn(we, a, sel, d, lat, rd, saw, c1_csb, c1_web, c1_mask, c1_addr);
      check($sformatf("rnd%0d lat", n),      32'(lat), 32'(mlat));
      check($sformatf("rnd%0d csb_seen", n), 32'(saw), 32'(touch));
      if (!we && mlat == 3) check($sformatf("rnd%0d rdata", n), rd, rexp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_sram_ctrl.md
Name: wb_sram_ctrl

Overview:
- Wishbone classic slave that turns management-core bus cycles into single-port accesses on the 512x32 SRAM macro wrapper (port 0: csb0/web0/wmask0/addr0/din0/dout0).
- Sits directly upstream of the SRAM. Decodes its address window, sequences the macro's synchronous read (data valid one clock after the address is sampled), registers read data, and returns a one-cycle ack.
- Port 1 of the SRAM wrapper is not driven by this block: tie csb1=1 at integration.

Parameters:
- ADDR_WIDTH, 9: SRAM word-address width.
- DATA_WIDTH, 32: data width. Fixed at 32 for this bus.
- NUM_WMASKS, 4: byte lanes, equal to DATA_WIDTH/8.
- BASE_ADDR, 32'h0000_0000: byte base of the window. Must be aligned to 4<<ADDR_WIDTH.

Ports:
- core_clk  in  1  clock; also the SRAM clk0.
- core_rstn  in  1  asynchronous active-low reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1=write.
- wb_sel_i  in  4  byte selects.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  transfer acknowledge, registered one-cycle pulse.
- sram_csb0  out  1  SRAM chip select, active low.
- sram_web0  out  1  SRAM write enable, active low.
- sram_wmask0  out  NUM_WMASKS  byte write mask, active high.
- sram_addr0  out  ADDR_WIDTH  word address.
- sram_din0  out  DATA_WIDTH  write data.
- sram_dout0  in  DATA_WIDTH  SRAM read data, valid the cycle after the access edge.

Behaviour:
- Clock and reset: one clock, core_clk. Reset core_rstn is asynchronous, active-low.
- Reset values:
  - state=IDLE, wb_ack_o=0, wb_dat_o=0.
  - sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0.
- All outputs are registered.
- Hit: wb_cyc_i & wb_stb_i & (wb_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]).
  - Word address = wb_adr_i[ADDR_WIDTH+1:2]. Bits [1:0] are ignored.
- Miss: never acked and never touches the SRAM; the bus decoder owns misses.
- FSM states: IDLE, ACCESS, RDWAIT, ACK.
  - IDLE:
    - On hit, register addr0=word address, din0=wb_dat_i, web0=~wb_we_i, wmask0 = wb_we_i ? wb_sel_i : 0.
    - Set csb0=0, except csb0 stays 1 for a write with wb_sel_i==0.
    - Go to ACCESS.
  - ACCESS: the macro samples the access at the end of this cycle.
    - Next cycle: csb0=1, web0=1, wmask0=0.
    - Write: go to ACK with ack=1.
    - Read: go to RDWAIT.
  - RDWAIT: wb_dat_o <= sram_dout0; ack=1; go to ACK.
  - ACK: wb_ack_o=1 for exactly this cycle, then IDLE with ack=0.
    - IDLE does not re-sample the bus until the cycle after ACK, so a strobe held through the ack cycle does not retrigger.
- Latency, with the hit seen in cycle 0:
  - Write ack in cycle 2.
  - Read ack in cycle 3, with wb_dat_o valid in the same cycle and held until the next read completes.
- Abort: wb_cyc_i=0 in ACCESS or RDWAIT:
  - Go to IDLE without ack; wb_dat_o is not updated.
  - An SRAM write already committed in ACCESS stays committed.
- Back-to-back: a new hit is accepted in the IDLE cycle following ACK. Maximum throughput is one write per 3 cycles and one read per 4 cycles.
- Reset mid-operation: all outputs return to reset values immediately. csb0 goes high asynchronously, so no partial access is issued after reset asserts.
- wb_dat_i, wb_sel_i and wb_we_i are sampled only in IDLE. Changes after acceptance are ignored.

Decomposition:
- Shared package (mgmt_sram_pkg):
  - State encoding constants: IDLE=2'd0, ACCESS=2'd1, RDWAIT=2'd2, ACK=2'd3.
  - Default SRAM_ADDR_WIDTH=9 and SRAM_NUM_WMASKS=4.
- No sub-module. A single FSM plus output registers is sufficient; the address-window compare stays inline.

Test Plan:
- Write then read: write 0xDEADBEEF to BASE+0x10 with sel=4'hF, then read BASE+0x10 -> write ack in cycle 2; addr0=4, wmask0=4'hF, web0=0 in cycle 1; read ack in cycle 3 with wb_dat_o=0xDEADBEEF.
- Byte write: preload 0x11223344 at word 7, then write 0xAABBCCDD with sel=4'b0101 -> wmask0=4'b0101; readback=0x11BB33DD.
- Miss: access BASE+(4<<ADDR_WIDTH) -> csb0 stays 1 and no ack within 10 cycles. Also cover the wrap edge: address 0x7FC within the window maps to addr0=511 and returns its data.
- Abort: drop wb_cyc_i in RDWAIT -> no ack, wb_dat_o keeps its previous value, FSM back in IDLE; the next read acks normally.
- Reset mid-read: deassert core_rstn during ACCESS -> csb0=1, ack=0, wb_dat_o=0 immediately; after release, a new write completes with 2-cycle latency.
- Back-to-back with sel=0: write with sel=0 -> acked in cycle 2, csb0 never asserted; the following read is accepted the cycle after ACK.
